regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Write-back controller for the 32x32 register file.
- Shares the single register-file write port between two requesters: the ALU result path (req0) and the load/memory path (req1).
- Sequences byte and halfword partial writes as read-modify-write, so the register file only ever sees full-word writes.
- Sits between the execute/memory stages and the register file write/read ports.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register address width.
- RD_LAT, 1, read latency in cycles (1..2). The RD_LAT-th cycle of an rf_re assertion carries valid rf_rdata; RD_LAT=1 means combinational read.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  ALU write-back request valid.
- req0_ready  out  1  ALU request accepted when valid&&ready.
- req0_addr  in  ADDR_W  destination register.
- req0_data  in  DATA_W  write data, right-justified for partial sizes.
- req0_size  in  2  wb_size_t: byte, half, word.
- req1_valid, req1_ready, req1_addr, req1_data, req1_size  same as req0, memory/load path.
- rf_we  out  1  register-file write enable, one-cycle pulse.
- rf_waddr  out  ADDR_W  write address.
- rf_wdata  out  DATA_W  merged full-word write data.
- rf_re  out  1  read enable for the RMW read.
- rf_raddr  out  ADDR_W  RMW read address.
- rf_rdata  in  DATA_W  read data.
- wb_done  out  1  one-cycle pulse when a request retires.
- wb_id  out  1  requester of the retiring request (0=ALU, 1=MEM); valid with wb_done.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (async, rst_n=0): state=IDLE. All outputs 0: rf_we, rf_re, readys, wb_done, wb_id, busy, and address/data outputs. Any in-flight request is dropped with no write. Arbitration pointer points to req1.
- All outputs are registered. reqN_ready is high only in IDLE, and only for the requester that wins arbitration this cycle.
- Arbitration (macro absent): fixed priority, req1 over req0. The loser's ready stays low and its valid/payload must be held.
- On accept, latch addr/data/size/id.
- FSM states: IDLE, READ, WRITE, DONE.
  - IDLE: on accept, go to WRITE if size=word or addr=0; otherwise go to READ.
  - READ: rf_re=1, rf_raddr=latched addr, held for RD_LAT cycles via counter. rf_rdata is sampled on the final READ cycle. Then go to WRITE.
  - WRITE: one cycle. rf_we=1 and rf_waddr=addr, except addr=0 forces rf_we=0 (r0 writes discarded). rf_wdata:
    - word: data.
    - half: {old[31:16], data[15:0]}.
    - byte: {old[31:8], data[7:0]}.
    - size 2'b11 is treated as word.
    - Go to DONE.
  - DONE: wb_done=1, wb_id=latched id, go to IDLE.
- Latency from accept edge T:
  - word: rf_we at cycle T+1, wb_done at T+2, next accept possible at T+3.
  - partial: READ occupies T+1..T+RD_LAT, rf_we at T+RD_LAT+1, wb_done at T+RD_LAT+2.
- Upper bits of data above the write size are ignored for partial writes.
- Simultaneous valid on both requesters: exactly one is granted per IDLE cycle; the other is served on the next IDLE visit.
- busy=1 in READ, WRITE and DONE.

Optional Feature:
- Macro WB_ROUND_ROBIN_EN.
- Defined: a 1-bit last-grant pointer decides ties. When both requesters are valid, the one not granted last wins. A lone valid is always granted. Pointer updates on each accept; reset value favours req1.
- Undefined: fixed priority req1 > req0 and no pointer flop.

Decomposition:
- Package wb_pkg holds:
  - wb_size_t enum: WB_BYTE=2'b00, WB_HALF=2'b01, WB_WORD=2'b10.
  - wb_state_t enum: IDLE, READ, WRITE, DONE.
  - Constants REG_ZERO=5'd0, REQ_ALU=1'b0, REQ_MEM=1'b1.
- One sub-module: wb_merge, a combinational byte/half/word merge of old and new data by size, instantiated in WRITE.

Test Plan:
- Reset mid-operation: assert rst_n=0 during READ of a byte write -> no rf_we, all outputs 0, state IDLE.
- Word write: req0 addr=5, data=0xDEADBEEF, size=word -> rf_we at T+1 with waddr=5 and wdata=0xDEADBEEF, wb_done with id=0 at T+2, rf_re never asserted.
- Byte RMW, RD_LAT=1: reg 9 holds 0x11223344; req1 addr=9, data=0xFFFFFFAA, size=byte -> rf_re with raddr=9 at T+1, rf_we at T+2 with wdata=0x112233AA.
- Half RMW, RD_LAT=2: reg 3 holds 0xCAFEBABE; data=0x00001234, size=half -> two rf_re cycles, then wdata=0xCAFE1234.
- Contention: both requesters valid continuously.
  - Fixed build: req1 always granted, req0 starves while req1 stays valid.
  - WB_ROUND_ROBIN_EN build: grants alternate 1,0,1,0; req0 held stable until accepted.
- r0 write: req0 addr=0, data=0x1, size=byte -> no rf_re, no rf_we, wb_done still pulses with id=0.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file write-back arbiter.
// Imported by wb_merge and regfile_wb_arbiter.
package wb_pkg;

    typedef enum logic [1:0] {
        WB_BYTE = 2'b00,
        WB_HALF = 2'b01,
        WB_WORD = 2'b10
    } wb_size_t;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        DONE
    } wb_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic       REQ_ALU  = 1'b0;
    localparam logic       REQ_MEM  = 1'b1;

    // Byte and half writes need the old register value; 2'b11 behaves as a word.
    function automatic logic is_partial(input logic [1:0] size);
        return (size == WB_BYTE) || (size == WB_HALF);
    endfunction

endpackage

// File: rtl/wb_merge.sv
// Combinational merge of new write data into the old register value by size.
// Sizes other than byte/half pass the new word through unchanged.
module wb_merge
    import wb_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] old_data,
    input  logic [DATA_W-1:0] new_data,
    input  logic [1:0]        size,
    output logic [DATA_W-1:0] merged
);

    always_comb begin
        // NOTE: default assignment first so every path drives merged and no latch is inferred.
        merged = new_data;
        case (size)
            WB_BYTE: merged = {old_data[DATA_W-1:8],  new_data[7:0]};
            WB_HALF: merged = {old_data[DATA_W-1:16], new_data[15:0]};
            default: merged = new_data;
        endcase
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the register-file write port: two requesters, partial
// writes as read-modify-write. Define WB_ROUND_ROBIN_EN for round-robin ties.
module regfile_wb_arbiter
    import wb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    input  logic [1:0]        req0_size,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    input  logic [1:0]        req1_size,

    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              rf_re,
    output logic [ADDR_W-1:0] rf_raddr,
    input  logic [DATA_W-1:0] rf_rdata,

    output logic              wb_done,
    output logic              wb_id,
    output logic              busy
);

    localparam logic [1:0] RD_LAST = 2'(RD_LAT - 1);

    wb_state_t         state;
    logic [1:0]        rd_cnt;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_data;
    logic [1:0]        lat_size;
    logic              lat_id;

    logic              acc0;
    logic              acc1;
    logic              acc_id;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_data;
    logic [1:0]        acc_size;
    logic              acc_direct;
    logic              gnt0;
    logic              gnt1;
    logic [DATA_W-1:0] merged;

    // Readies are one-hot and only high in IDLE, so valid&&ready is the accept.
    assign acc0       = req0_valid && req0_ready;
    assign acc1       = req1_valid && req1_ready;
    assign acc_id     = acc1 ? REQ_MEM   : REQ_ALU;
    assign acc_addr   = acc1 ? req1_addr : req0_addr;
    assign acc_data   = acc1 ? req1_data : req0_data;
    assign acc_size   = acc1 ? req1_size : req0_size;
    assign acc_direct = !is_partial(acc_size) || (acc_addr == ADDR_W'(REG_ZERO));

`ifdef WB_ROUND_ROBIN_EN
    logic rr_prio;  // requester favoured on a tie: the one not granted last

    assign gnt1 = req1_valid && (!req0_valid || (rr_prio == REQ_MEM));
    assign gnt0 = req0_valid && (!req1_valid || (rr_prio == REQ_ALU));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_prio <= REQ_MEM;
        end else if (acc0 || acc1) begin
            rr_prio <= ~acc_id;
        end
    end
`else
    assign gnt1 = req1_valid;
    assign gnt0 = req0_valid && !req1_valid;
`endif

    wb_merge #(.DATA_W(DATA_W)) u_merge (
        .old_data (rf_rdata),
        .new_data (lat_data),
        .size     (lat_size),
        .merged   (merged)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rd_cnt     <= '0;
            lat_addr   <= '0;
            lat_data   <= '0;
            lat_size   <= '0;
            lat_id     <= REQ_ALU;
            req0_ready <= 1'b0;
            req1_ready <= 1'b0;
            rf_we      <= 1'b0;
            rf_waddr   <= '0;
            rf_wdata   <= '0;
            rf_re      <= 1'b0;
            rf_raddr   <= '0;
            wb_done    <= 1'b0;
            wb_id      <= 1'b0;
            busy       <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout so every output reflects the state being entered.
            rf_we   <= 1'b0;
            wb_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (acc0 || acc1) begin
                        lat_addr   <= acc_addr;
                        lat_data   <= acc_data;
                        lat_size   <= acc_size;
                        lat_id     <= acc_id;
                        req0_ready <= 1'b0;
                        req1_ready <= 1'b0;
                        busy       <= 1'b1;
                        if (acc_direct) begin
                            state    <= WRITE;
                            rf_we    <= (acc_addr != ADDR_W'(REG_ZERO));
                            rf_waddr <= acc_addr;
                            rf_wdata <= acc_data;
                        end else begin
                            state    <= READ;
                            rf_re    <= 1'b1;
                            rf_raddr <= acc_addr;
                            rd_cnt   <= '0;
                        end
                    end else begin
                        req0_ready <= gnt0;
                        req1_ready <= gnt1;
                    end
                end
                READ: begin
                    // rf_rdata is valid on the last READ cycle; merge it straight into the write.
                    if (rd_cnt == RD_LAST) begin
                        state    <= WRITE;
                        rf_re    <= 1'b0;
                        rf_we    <= 1'b1;
                        rf_waddr <= lat_addr;
                        rf_wdata <= merged;
                    end else begin
                        rd_cnt <= rd_cnt + 2'd1;
                    end
                end
                WRITE: begin
                    state   <= DONE;
                    wb_done <= 1'b1;
                    wb_id   <= lat_id;
                end
                DONE: begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    req0_ready <= gnt0;
                    req1_ready <= gnt1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: two instances (RD_LAT=1 and RD_LAT=2), each with
// its own register-file model, checked against a transaction-level reference.
module tb_regfile_wb_arbiter;
    import wb_pkg::*;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
        logic [1:0]  size;
    } req_t;

    logic        clk;
    logic        rst_n;

    logic        req0_valid [2];
    logic        req0_ready [2];
    logic [4:0]  req0_addr  [2];
    logic [31:0] req0_data  [2];
    logic [1:0]  req0_size  [2];
    logic        req1_valid [2];
    logic        req1_ready [2];
    logic [4:0]  req1_addr  [2];
    logic [31:0] req1_data  [2];
    logic [1:0]  req1_size  [2];
    logic        rf_we      [2];
    logic [4:0]  rf_waddr   [2];
    logic [31:0] rf_wdata   [2];
    logic        rf_re      [2];
    logic [4:0]  rf_raddr   [2];
    logic        wb_done    [2];
    logic        wb_id      [2];
    logic        busy       [2];

    logic [31:0] rf_mem  [2][32];
    logic [31:0] ref_mem [2][32];
    int          wr_cnt  [2] = '{0, 0};
    int          re_cnt  [2] = '{0, 0};

    logic        load_en   = 1'b0;
    int          load_lane = 0;
    logic [4:0]  load_addr = '0;
    logic [31:0] load_data = '0;

    int   errors = 0;
    int   checks = 0;
    logic model_last [2];
    logic grant_log [$];
    req_t pq0 [$];
    req_t pq1 [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_lane
        logic [31:0] rdata;
        // Real data only on the RD_LAT-th cycle of a read; inverted garbage otherwise.
        assign rdata = (rf_re[g] && (re_cnt[g] + 1 == g + 1)) ? rf_mem[g][rf_raddr[g]]
                                                              : ~rf_mem[g][rf_raddr[g]];
        regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .RD_LAT(g + 1)) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .req0_valid (req0_valid[g]),
            .req0_ready (req0_ready[g]),
            .req0_addr  (req0_addr[g]),
            .req0_data  (req0_data[g]),
            .req0_size  (req0_size[g]),
            .req1_valid (req1_valid[g]),
            .req1_ready (req1_ready[g]),
            .req1_addr  (req1_addr[g]),
            .req1_data  (req1_data[g]),
            .req1_size  (req1_size[g]),
            .rf_we      (rf_we[g]),
            .rf_waddr   (rf_waddr[g]),
            .rf_wdata   (rf_wdata[g]),
            .rf_re      (rf_re[g]),
            .rf_raddr   (rf_raddr[g]),
            .rf_rdata   (rdata),
            .wb_done    (wb_done[g]),
            .wb_id      (wb_id[g]),
            .busy       (busy[g])
        );
    end

    always @(posedge clk) begin
        for (int l = 0; l < 2; l++) begin
            if (rf_we[l]) begin
                rf_mem[l][rf_waddr[l]] <= rf_wdata[l];
                wr_cnt[l] <= wr_cnt[l] + 1;
            end
            re_cnt[l] <= rf_re[l] ? re_cnt[l] + 1 : 0;
        end
        if (load_en) rf_mem[load_lane][load_addr] <= load_data;
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_merge(input logic [31:0] old, input logic [31:0] data,
                                              input logic [1:0] size);
        logic [31:0] mask;
        mask = (size == 2'b00) ? 32'h0000_00FF : (size == 2'b01) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
        return (old & ~mask) | (data & mask);
    endfunction

    function automatic logic model_winner(input logic v0, input logic v1, input logic last);
        if (v0 && !v1) return 1'b0;
        if (v1 && !v0) return 1'b1;
`ifdef WB_ROUND_ROBIN_EN
        return !last;
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic [48:0] outs(input int l);
        return {req0_ready[l], req1_ready[l], rf_we[l], rf_re[l], wb_done[l], wb_id[l], busy[l],
                rf_waddr[l], rf_wdata[l], rf_raddr[l]};
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input int l, input logic [4:0] a, input logic [31:0] v);
        load_en = 1'b1; load_lane = l; load_addr = a; load_data = v;
        step();
        load_en = 1'b0;
        ref_mem[l][a] = v;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        for (int l = 0; l < 2; l++) begin
            req0_valid[l] = 1'b0;
            req1_valid[l] = 1'b0;
            model_last[l] = 1'b0;
        end
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic drive_heads(input int l);
        req0_valid[l] = (pq0.size() > 0);
        req1_valid[l] = (pq1.size() > 0);
        if (pq0.size() > 0) {req0_addr[l], req0_data[l], req0_size[l]} = pq0[0];
        if (pq1.size() > 0) {req1_addr[l], req1_data[l], req1_size[l]} = pq1[0];
    endtask

    // One accepted transaction: grant check, then latency/write/retire checks.
    task automatic accept(input int l);
        logic id, exp_id, did;
        req_t r;
        logic [31:0] exp_wdata, wd;
        logic [4:0] wa;
        int exp_re, exp_we_k, exp_done_k, re_n, we_n, we_k, done_k;
        bit exp_we, raddr_bad, busy_bad;
        id = req1_ready[l];
        exp_id = model_winner(req0_valid[l], req1_valid[l], model_last[l]);
        checks++;
        if ((req0_ready[l] && req1_ready[l]) || id !== exp_id) begin
            errors++;
            $display("FAIL grant lane=%0d: ready0=%b ready1=%b, required grant to req%0d",
                     l, req0_ready[l], req1_ready[l], exp_id);
        end
        if ((id && !req1_valid[l]) || (!id && !req0_valid[l])) begin
            step();
            return;
        end
        r = id ? pq1.pop_front() : pq0.pop_front();
        step();
        model_last[l] = id;
        grant_log.push_back(id);
        exp_we     = (r.addr != 5'd0);
        exp_re     = ((r.size == 2'b00 || r.size == 2'b01) && exp_we) ? l + 1 : 0;
        exp_we_k   = exp_re + 1;
        exp_done_k = exp_re + 2;
        exp_wdata  = ref_merge(ref_mem[l][r.addr], r.data, r.size);
        if (exp_we) ref_mem[l][r.addr] = exp_wdata;
        drive_heads(l);
        re_n = 0; we_n = 0; we_k = -1; done_k = -1; did = 1'bx;
        wa = 'x; wd = 'x; raddr_bad = 0; busy_bad = 0;
        for (int k = 1; k <= 8; k++) begin
            if (rf_re[l]) begin
                re_n++;
                if (rf_raddr[l] !== r.addr) raddr_bad = 1;
            end
            if (rf_we[l]) begin
                we_n++; we_k = k; wa = rf_waddr[l]; wd = rf_wdata[l];
            end
            if (busy[l] !== 1'b1) busy_bad = 1;
            if (wb_done[l]) begin
                done_k = k; did = wb_id[l];
                break;
            end
            step();
        end
        checks++;
        if (re_n != exp_re || raddr_bad) begin
            errors++;
            $display("FAIL rmw_read lane=%0d addr=%0d: %0d rf_re cycles (raddr_bad=%0d), required %0d",
                     l, r.addr, re_n, raddr_bad, exp_re);
        end
        checks++;
        if (exp_we ? (we_n != 1 || we_k != exp_we_k || wa !== r.addr || wd !== exp_wdata) : (we_n != 0)) begin
            errors++;
            $display("FAIL write lane=%0d: %0d writes at k=%0d addr=%0d data=%h, required %0d at k=%0d addr=%0d data=%h",
                     l, we_n, we_k, wa, wd, exp_we, exp_we_k, r.addr, exp_wdata);
        end
        checks++;
        if (done_k != exp_done_k || did !== id) begin
            errors++;
            $display("FAIL retire lane=%0d: wb_done at k=%0d id=%b, required k=%0d id=%b",
                     l, done_k, did, exp_done_k, id);
        end
        checks++;
        if (busy_bad) begin
            errors++;
            $display("FAIL busy_high lane=%0d: busy dropped mid-request, required 1", l);
        end
        step();
        checks++;
        if (busy[l] !== 1'b0) begin
            errors++;
            $display("FAIL busy_idle lane=%0d: busy=%b after retire, required 0", l, busy[l]);
        end
        if (req0_valid[l] || req1_valid[l]) begin
            checks++;
            if (!(req0_ready[l] || req1_ready[l])) begin
                errors++;
                $display("FAIL back_to_back lane=%0d: no ready on first IDLE cycle, required one", l);
            end
        end
    endtask

    task automatic run(input int l);
        int budget;
        budget = 0;
        drive_heads(l);
        while (pq0.size() + pq1.size() > 0) begin
            if (req0_ready[l] || req1_ready[l]) begin
                accept(l);
                budget = 0;
            end else begin
                step();
                budget++;
                if (budget > 20) begin
                    checks++; errors++;
                    $display("FAIL arb_timeout lane=%0d: no ready after %0d cycles, required a grant", l, budget);
                    pq0.delete(); pq1.delete();
                end
            end
        end
        req0_valid[l] = 1'b0;
        req1_valid[l] = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        for (int l = 0; l < 2; l++) begin
            checks++;
            if (outs(l) !== '0) begin
                errors++;
                $display("FAIL reset_outs lane=%0d: outputs=%h, required 0", l, outs(l));
            end
        end
        apply_reset();
        step();
        for (int l = 0; l < 2; l++) begin
            checks++;
            if (outs(l) !== '0) begin
                errors++;
                $display("FAIL post_reset_idle lane=%0d: outputs=%h, required 0", l, outs(l));
            end
        end
    endtask

    task automatic test_reset_midop(input int l);
        int wr0, n;
        preload(l, 5'd9, 32'h1122_3344);
        req1_addr[l] = 5'd9; req1_data[l] = 32'hFFFF_FFAA; req1_size[l] = WB_BYTE;
        req1_valid[l] = 1'b1;
        n = 0;
        while (!req1_ready[l] && n < 10) begin step(); n++; end
        step();
        req1_valid[l] = 1'b0;
        checks++;
        if (rf_re[l] !== 1'b1) begin
            errors++;
            $display("FAIL midop_in_read lane=%0d: rf_re=%b, required 1", l, rf_re[l]);
        end
        wr0 = wr_cnt[l];
        rst_n = 1'b0;
        #1;
        checks++;
        if (outs(l) !== '0) begin
            errors++;
            $display("FAIL midop_reset_outs lane=%0d: outputs=%h, required 0", l, outs(l));
        end
        apply_reset();
        step(); step(); step();
        checks++;
        if (wr_cnt[l] != wr0 || rf_mem[l][9] !== 32'h1122_3344 || busy[l] !== 1'b0) begin
            errors++;
            $display("FAIL midop_dropped lane=%0d: writes=%0d reg9=%h busy=%b, required writes=%0d reg9=11223344 busy=0",
                     l, wr_cnt[l] - wr0, rf_mem[l][9], busy[l], 0);
        end
    endtask

    task automatic check_reg(input int l, input string name, input logic [4:0] a, input logic [31:0] v);
        checks++;
        if (rf_mem[l][a] !== v) begin
            errors++;
            $display("FAIL %s lane=%0d: reg%0d=%h, required %h", name, l, a, rf_mem[l][a], v);
        end
    endtask

    task automatic test_word(input int l);
        pq0.push_back('{5'd5, 32'hDEAD_BEEF, WB_WORD});
        run(l);
        check_reg(l, "word_write", 5'd5, 32'hDEAD_BEEF);
    endtask

    task automatic test_byte(input int l);
        preload(l, 5'd9, 32'h1122_3344);
        pq1.push_back('{5'd9, 32'hFFFF_FFAA, WB_BYTE});
        run(l);
        check_reg(l, "byte_rmw", 5'd9, 32'h1122_33AA);
    endtask

    task automatic test_half(input int l);
        preload(l, 5'd3, 32'hCAFE_BABE);
        pq0.push_back('{5'd3, 32'h0000_1234, WB_HALF});
        run(l);
        check_reg(l, "half_rmw", 5'd3, 32'hCAFE_1234);
    endtask

    task automatic test_r0_and_size3(input int l);
        pq0.push_back('{5'd0, 32'h0000_0001, WB_BYTE});
        run(l);
        check_reg(l, "r0_untouched", 5'd0, ref_mem[l][0]);
        pq1.push_back('{5'd7, 32'h89AB_CDEF, 2'b11});
        run(l);
        check_reg(l, "size3_word", 5'd7, 32'h89AB_CDEF);
    endtask

    task automatic test_contention(input int l);
        logic exp_seq [8];
        bit bad;
        apply_reset();
        grant_log.delete();
        for (int i = 0; i < 4; i++) begin
            pq0.push_back('{5'($urandom_range(1, 31)), $urandom, 2'($urandom_range(0, 3))});
            pq1.push_back('{5'($urandom_range(1, 31)), $urandom, 2'($urandom_range(0, 3))});
        end
        run(l);
        for (int i = 0; i < 8; i++) begin
`ifdef WB_ROUND_ROBIN_EN
            exp_seq[i] = (i % 2 == 0);
`else
            exp_seq[i] = (i < 4);
`endif
        end
        bad = (grant_log.size() != 8);
        for (int i = 0; i < 8 && !bad; i++) if (grant_log[i] !== exp_seq[i]) bad = 1;
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL contention_order lane=%0d: %0d grants %p, required 8 grants %p",
                     l, grant_log.size(), grant_log, exp_seq);
        end
    endtask

    task automatic test_random(input int l);
        int n;
        n = 0;
        for (int i = 0; i < 16; i++) begin
            req_t r;
            r = '{5'($urandom_range(0, 31)), $urandom, 2'($urandom_range(0, 3))};
            if ($urandom_range(0, 1) == 1) pq1.push_back(r); else pq0.push_back(r);
        end
        run(l);
        for (int a = 0; a < 32; a++) if (rf_mem[l][a] !== ref_mem[l][a]) n++;
        checks++;
        if (n != 0) begin
            errors++;
            $display("FAIL regfile_contents lane=%0d: %0d registers differ from reference, required 0", l, n);
        end
    endtask

    initial begin
        for (int l = 0; l < 2; l++) begin
            req0_valid[l] = 1'b0; req1_valid[l] = 1'b0;
            req0_addr[l] = '0; req0_data[l] = '0; req0_size[l] = '0;
            req1_addr[l] = '0; req1_data[l] = '0; req1_size[l] = '0;
            model_last[l] = 1'b0;
        end
        test_reset();
        for (int l = 0; l < 2; l++)
            for (int a = 0; a < 32; a++) preload(l, 5'(a), $urandom);
        for (int l = 0; l < 2; l++) begin
            test_reset_midop(l);
            test_word(l);
            test_byte(l);
            test_half(l);
            test_r0_and_size3(l);
            test_contention(l);
            test_random(l);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
